// File: rtl/sigmoid_alu_neuron_sequencer.sv
// Purpose     : runs one fully-connected layer through the shared sigmoid calculator, one neuron at a time.
// Latency     : the last beat is accepted at edge t and out_valid rises after edge t+1; at least NUM_INPUTS+2 cycles per neuron.
// Backpressure: in_ready is high only while accumulating; out_valid holds out_sigma and out_index stable until out_ready.
// Option      : define SIGMOID_SEQ_SAT_EN to make the accumulator saturate. By default it wraps modulo 2^14.
module sigmoid_alu_neuron_sequencer #(
  parameter int NUM_INPUTS  = 16,
  parameter int NUM_NEURONS = 10,
  localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
  localparam int CNT_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic             clk_i,
  input  logic             n_rst_i,
  input  logic             start_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       pixel_i,
  input  logic [3:0]       weight_i,
  input  logic [3:0]       bias_i,
  output logic [13:0]      calc_accum_o,
  output logic [3:0]       calc_bias_o,
  input  logic [3:0]       calc_sigma_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [3:0]       out_sigma_o,
  output logic [IDX_W-1:0] out_index_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_EVAL   = 2'd2,
    S_OUTPUT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BEAT   = CNT_W'(NUM_INPUTS - 1);
  localparam logic [IDX_W-1:0] LAST_NEURON = IDX_W'(NUM_NEURONS - 1);

  state_t             state_q;
  logic [13:0]        acc_q;
  logic [3:0]         bias_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic [3:0]         sigma_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;
  logic               done_q;

  // The pixel is unsigned, so a zero is prepended. The 9-bit signed product covers -120..105.
  logic signed [8:0]  prod_d;
  logic [13:0]        acc_d;

  // Form the product of the current beat.
  always_comb begin
    prod_d = $signed({5'b0_0000, pixel_i}) * $signed({{5{weight_i[3]}}, weight_i});
  end

`ifdef SIGMOID_SEQ_SAT_EN
  // One guard bit makes overflow visible. A clamped value re-enters the range
  // only when later beats carry the sum back inside it.
  logic signed [14:0] sum_d;

  // Add the product with saturation at +8191 and -8192.
  always_comb begin
    sum_d = $signed({acc_q[13], acc_q}) + $signed({{6{prod_d[8]}}, prod_d});
    if (sum_d[14] != sum_d[13]) begin
      acc_d = sum_d[14] ? 14'h2000 : 14'h1FFF;
    end else begin
      acc_d = sum_d[13:0];
    end
  end
`else
  // Add the product with plain two's-complement wrap-around.
  always_comb begin
    acc_d = acc_q + {{5{prod_d[8]}}, prod_d};
  end
`endif

  // Sequencer state machine. Every port-facing flag is registered here.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      bias_q      <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      sigma_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q    <= S_ACCUM;
            acc_q      <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        S_ACCUM: begin
          // in_ready is high in this state, so a valid beat is an accepted beat.
          if (in_valid_i) begin
            acc_q <= acc_d;
            if (cnt_q == LAST_BEAT) begin
              cnt_q      <= '0;
              bias_q     <= bias_i;
              in_ready_q <= 1'b0;
              state_q    <= S_EVAL;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        S_EVAL: begin
          // The calculator is combinational on acc_q and bias_q, which have settled by now.
          sigma_q     <= calc_sigma_i;
          out_valid_q <= 1'b1;
          state_q     <= S_OUTPUT;
        end
        S_OUTPUT: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            if (idx_q == LAST_NEURON) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q      <= idx_q + IDX_W'(1);
              acc_q      <= '0;
              in_ready_q <= 1'b1;
              state_q    <= S_ACCUM;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready_o   = in_ready_q;
  assign out_valid_o  = out_valid_q;
  assign out_sigma_o  = sigma_q;
  assign out_index_o  = idx_q;
  assign calc_accum_o = acc_q;
  assign calc_bias_o  = bias_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_sigmoid_alu_neuron_sequencer.sv
// Bench for sigmoid_alu_neuron_sequencer: a scoreboard queue fed by the stimulus and drained by a monitor.
// It drives a small layer (4 inputs, 2 neurons) with directed and random passes.
// A second instance (100 inputs, 1 neuron) exercises accumulator overflow.
module tb_sigmoid_alu_neuron_sequencer;
  localparam int NI     = 4;
  localparam int NN     = 2;
  localparam int BIG_NI = 100;

  logic clk   = 1'b0;
  logic n_rst = 1'b1;
  always #5 clk = ~clk;

  logic        start, in_valid, in_ready, out_valid, out_ready, busy, done;
  logic [3:0]  pixel, weight, bias, calc_bias, calc_sigma, out_sigma;
  logic [13:0] calc_accum;
  logic [0:0]  out_index;

  logic        b_start, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy, b_done;
  logic [3:0]  b_pixel, b_weight, b_bias, b_calc_bias, b_calc_sigma, b_out_sigma;
  logic [13:0] b_calc_accum;
  logic [0:0]  b_out_index;

  int  pass_cnt  = 0;
  int  check_cnt = 0;
  time start_t   = 0;
  time done_t    = 0;
  bit  rnd_rdy_en = 1'b0;

  typedef struct {
    int accum;
    int bias;
    int sigma;
    int idx;
  } exp_t;
  exp_t sb_q[$];

  // Sign-extend 14-bit and 4-bit values to int.
  function automatic int s14(logic [13:0] v);
    return int'($signed(v));
  endfunction

  function automatic int s4(logic [3:0] v);
    return int'($signed(v));
  endfunction

  // Stand-in for the sigmoid calculator.
  // x = accum + 2*bias; the result saturates at 0 and 8 and is centred on 4.
  function automatic int sig_calc(int acc, int b);
    int x;
    x = acc + 2 * b;
    if (x >= 16) return 8;
    if (x <= -16) return 0;
    return 4 + (x >>> 2);
  endfunction

  // One accumulation step on the 14-bit register, modelled in integer arithmetic.
  function automatic int acc_step(int acc, int p, int w);
    int s;
    s = acc + p * w;
`ifdef SIGMOID_SEQ_SAT_EN
    if (s > 8191) s = 8191;
    if (s < -8192) s = -8192;
`else
    s = (((s + 8192) % 16384) + 16384) % 16384 - 8192;
`endif
    return s;
  endfunction

  assign calc_sigma   = 4'(sig_calc(s14(calc_accum), s4(calc_bias)));
  assign b_calc_sigma = 4'(sig_calc(s14(b_calc_accum), s4(b_calc_bias)));

  sigmoid_alu_neuron_sequencer #(.NUM_INPUTS(NI), .NUM_NEURONS(NN)) dut (
    .clk_i(clk), .n_rst_i(n_rst), .start_i(start),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .pixel_i(pixel), .weight_i(weight), .bias_i(bias),
    .calc_accum_o(calc_accum), .calc_bias_o(calc_bias), .calc_sigma_i(calc_sigma),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_sigma_o(out_sigma), .out_index_o(out_index),
    .busy_o(busy), .done_o(done)
  );

  sigmoid_alu_neuron_sequencer #(.NUM_INPUTS(BIG_NI), .NUM_NEURONS(1)) dut_big (
    .clk_i(clk), .n_rst_i(n_rst), .start_i(b_start),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
    .pixel_i(b_pixel), .weight_i(b_weight), .bias_i(b_bias),
    .calc_accum_o(b_calc_accum), .calc_bias_o(b_calc_bias), .calc_sigma_i(b_calc_sigma),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
    .out_sigma_o(b_out_sigma), .out_index_o(b_out_index),
    .busy_o(b_busy), .done_o(b_done)
  );

  task automatic check(input string name, input int act, input int req);
    check_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: actual %0d required %0d", name, act, req);
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks the done pulse.
  bit hs_last_prev = 1'b0;
  always @(negedge clk) begin
    if (!n_rst) begin
      hs_last_prev = 1'b0;
    end else begin
      if (done || hs_last_prev) begin
        check("done_pulse", int'(done), int'(hs_last_prev));
        if (done) done_t = $time;
      end
      hs_last_prev = 1'b0;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("output_expected", int'(sb_q.size() > 0), 1);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("out_sigma",  int'(out_sigma),  e.sigma);
          check("out_index",  int'(out_index),  e.idx);
          check("calc_accum", s14(calc_accum),  e.accum);
          check("calc_bias",  s4(calc_bias),    e.bias);
          hs_last_prev = (e.idx == NN - 1);
        end
      end
    end
  end

  // Random consumer backpressure, active only while enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy_en) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1);
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},   int'(in_ready),   0);
    check({tag, "_out_valid"},  int'(out_valid),  0);
    check({tag, "_out_sigma"},  int'(out_sigma),  0);
    check({tag, "_out_index"},  int'(out_index),  0);
    check({tag, "_calc_accum"}, int'(calc_accum), 0);
    check({tag, "_calc_bias"},  int'(calc_bias),  0);
    check({tag, "_busy"},       int'(busy),       0);
    check({tag, "_done"},       int'(done),       0);
  endtask

  // Present one beat and return just after the edge that accepts it.
  // With gap set, in_valid stays low for one ACCUM cycle first.
  task automatic send_beat(input int p, input int w, input int b, input bit gap);
    int t;
    t = 0;
    pixel    = 4'(p);
    weight   = 4'(w);
    bias     = 4'(b);
    in_valid = !gap;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("beat_ready", int'(in_ready), 1);
    if (gap) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Push the expected result for a neuron, then send its beats.
  // Bias lines carry junk except on the last beat.
  task automatic do_neuron(input int idx, input int p[NI], input int w[NI], input int b,
                           input bit gaps, input bit rnd_gaps);
    exp_t e;
    int acc;
    acc = 0;
    for (int i = 0; i < NI; i++) acc = acc_step(acc, p[i], w[i]);
    e.accum = acc;
    e.bias  = b;
    e.sigma = sig_calc(acc, b);
    e.idx   = idx;
    sb_q.push_back(e);
    for (int i = 0; i < NI; i++) begin
      int bb;
      bit g;
      bb = (i == NI - 1) ? b : int'($urandom_range(0, 15)) - 8;
      g  = gaps | (rnd_gaps & ($urandom_range(0, 1) == 1));
      send_beat(p[i], w[i], bb, g);
    end
  endtask

  task automatic start_pass();
    int t;
    t = 0;
    while (busy && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("idle_before_start", int'(busy), 0);
    start = 1'b1;
    @(posedge clk);
    start_t = $time;
    #1;
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 1000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("pass_completes", int'(busy), 0);
    @(negedge clk);
    #1;
  endtask

  // Directed pass: accumulator 60 then -480, with optional one-cycle gaps before every beat.
  task automatic s1_pass(input bit gaps, input int exp_cycles);
    int p[NI];
    int w0[NI];
    int w1[NI];
    for (int i = 0; i < NI; i++) begin
      p[i]  = 15;
      w0[i] = 1;
      w1[i] = -8;
    end
    out_ready = 1'b1;
    start_pass();
    do_neuron(0, p, w0, 0, gaps, 1'b0);
    check("latency_eval_cycle", int'(out_valid), 0);
    @(posedge clk);
    #1;
    check("latency_output_cycle", int'(out_valid), 1);
    do_neuron(1, p, w1, 0, gaps, 1'b0);
    wait_idle();
    check(gaps ? "pass_cycles_gapped" : "pass_cycles_contig",
          int'((done_t - start_t - 5) / 10), exp_cycles);
  endtask

  task automatic random_pass(input bit narrow);
    int p[NI];
    int w[NI];
    start_pass();
    for (int n = 0; n < NN; n++) begin
      for (int i = 0; i < NI; i++) begin
        p[i] = narrow ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
        w[i] = int'($urandom_range(0, 15)) - 8;
      end
      do_neuron(n, p, w, int'($urandom_range(0, 15)) - 8, 1'b0, 1'b1);
    end
    wait_idle();
  endtask

  initial begin
    int p[NI];
    int w[NI];
    int t;
    int es;
    int big_acc;
    start = 1'b0; in_valid = 1'b0; pixel = '0; weight = '0; bias = '0; out_ready = 1'b1;
    b_start = 1'b0; b_in_valid = 1'b0; b_pixel = '0; b_weight = '0; b_bias = '0; b_out_ready = 1'b0;

    #2 n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    // Two neurons with continuous beats: 6 cycles per neuron.
    s1_pass(1'b0, 2 * (NI + 2));

    // Near-zero accumulations, with the calculator doubling the bias.
    out_ready = 1'b1;
    start_pass();
    for (int i = 0; i < NI; i++) p[i] = 1;
    w = '{1, -1, 0, 0};
    do_neuron(0, p, w, 0, 1'b0, 1'b0);
    w = '{-1, -1, 0, 0};
    do_neuron(1, p, w, 1, 1'b0, 1'b0);
    wait_idle();

    // Consumer stall: output held stable and junk beats left unconsumed.
    out_ready = 1'b0;
    start_pass();
    for (int i = 0; i < NI; i++) begin
      p[i] = int'($urandom_range(0, 3));
      w[i] = int'($urandom_range(0, 15)) - 8;
    end
    do_neuron(0, p, w, int'($urandom_range(0, 15)) - 8, 1'b0, 1'b0);
    es = sb_q[0].sigma;
    pixel = 4'd15; weight = 4'd7; in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("stall_valid_rise", int'(out_valid), 1);
    repeat (5) begin
      @(negedge clk);
      check("stall_valid",    int'(out_valid), 1);
      check("stall_sigma",    int'(out_sigma), es);
      check("stall_index",    int'(out_index), 0);
      check("stall_in_ready", int'(in_ready),  0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("stall_next_neuron", int'(in_ready), 1);
    for (int i = 0; i < NI; i++) begin
      p[i] = int'($urandom_range(0, 15));
      w[i] = int'($urandom_range(0, 15)) - 8;
    end
    do_neuron(1, p, w, int'($urandom_range(0, 15)) - 8, 1'b0, 1'b0);
    wait_idle();

    // Reset during the third beat of neuron 1.
    start_pass();
    for (int i = 0; i < NI; i++) begin
      p[i] = int'($urandom_range(0, 15));
      w[i] = int'($urandom_range(0, 15)) - 8;
    end
    do_neuron(0, p, w, 2, 1'b0, 1'b0);
    send_beat(3, 2, 0, 1'b0);
    send_beat(5, -1, 0, 1'b0);
    pixel = 4'd7; weight = 4'd3; in_valid = 1'b1;
    @(negedge clk);
    check("abort_third_beat_ready", int'(in_ready), 1);
    #1 n_rst = 1'b0;
    #1;
    check_reset_vals("abort");
    check("abort_sb_empty", sb_q.size(), 0);
    sb_q.delete();
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 n_rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", int'(done), 0);
      check("abort_idle",    int'(busy), 0);
    end
    @(posedge clk);
    #1;
    random_pass(1'b1);

    // The same pass with in_valid low every other cycle adds 4 cycles per neuron.
    s1_pass(1'b1, 2 * (NI + 2) + 2 * NI);

    // Random passes with random gaps and random consumer backpressure.
    rnd_rdy_en = 1'b1;
    for (int k = 0; k < 8; k++) random_pass(k[0]);
    rnd_rdy_en = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;

    // Overflow: 100 beats of 15 * -8.
    big_acc = 0;
    for (int i = 0; i < BIG_NI; i++) big_acc = acc_step(big_acc, 15, -8);
    b_pixel = 4'd15; b_weight = 4'b1000; b_bias = 4'd0; b_in_valid = 1'b1;
    b_start = 1'b1;
    @(posedge clk);
    #1;
    b_start = 1'b0;
    t = 0;
    @(negedge clk);
    while (!b_out_valid && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("big_valid",  int'(b_out_valid), 1);
    check("big_accum",  s14(b_calc_accum), big_acc);
    check("big_sigma",  int'(b_out_sigma), sig_calc(big_acc, 0));
    check("big_index",  int'(b_out_index), 0);
    b_in_valid = 1'b0;
    @(posedge clk);
    #1;
    b_out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("big_done",      int'(b_done),      1);
    check("big_idle",      int'(b_busy),      0);
    check("big_valid_low", int'(b_out_valid), 0);
    @(posedge clk);
    #1;
    check("big_done_one_cycle", int'(b_done), 0);

    repeat (3) @(posedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/sigmoid_alu_neuron_sequencer.md
# sigmoid_alu_neuron_sequencer

Sequences the shared sigmoid calculator for one fully-connected layer. For each of `NUM_NEURONS` neurons, the block accepts `NUM_INPUTS` pixel/weight beats and accumulates their signed products into a 14-bit accumulator. It then presents the accumulator and bias to the combinational sigmoid calculator and returns the registered 4-bit activation through a valid/ready output port. It sits between the weight/pixel fetch logic and the next-layer input buffer.

## Interface
- `NUM_INPUTS`, 16, input beats per neuron (≥1)
- `NUM_NEURONS`, 10, neurons per layer pass (≥1)
- `clk`  in  1  system clock, rising edge
- `n_rst`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a layer pass; sampled only in IDLE
- `in_valid`  in  1  pixel/weight beat valid
- `in_ready`  out  1  beat accepted when `in_valid & in_ready`
- `pixel`  in  4  unsigned pixel value, 0..15
- `weight`  in  4  signed weight, -8..7
- `bias`  in  4  neuron bias, sampled on the last beat of each neuron
- `calc_accum`  out  14  to sigmoid calculator `accum`; equals accumulator register
- `calc_bias`  out  4  to sigmoid calculator `bias`; equals bias register
- `calc_sigma`  in  4  sigmoid calculator result, combinational
- `out_valid`  out  1  activation valid
- `out_ready`  in  1  consumer accepts activation
- `out_sigma`  out  4  registered activation, 0..8
- `out_index`  out  $clog2(NUM_NEURONS) (min 1)  neuron number of `out_sigma`
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse after the final activation handshake

## Operation
- States: IDLE, ACCUM, EVAL, OUTPUT.
- IDLE to ACCUM on `start`. Clears the accumulator, beat counter and neuron index.
- `start` is ignored in all other states.
- ACCUM: `in_ready` = 1. Each accepted beat adds the 9-bit signed product of {1'b0,pixel} and `weight` (range -120..105) to the accumulator, sign-extended to 14 bits. The beat counter increments.
- Last beat (counter = NUM_INPUTS-1): the block latches `bias` and moves to EVAL. The counter resets.
- EVAL (exactly 1 cycle): `in_ready` = 0. The block registers `calc_sigma` into `out_sigma` and moves to OUTPUT.
- OUTPUT: `out_valid` = 1. `out_sigma` and `out_index` hold stable until `out_ready`.
- On handshake at the last neuron, the block returns to IDLE and pulses `done`.
- On handshake at any other neuron, the block increments the index, clears the accumulator and returns to ACCUM.
- `in_ready` = 0 outside ACCUM. Beats presented then are not consumed.
- The bias is not shifted here. The calculator applies its own x2 bias scaling.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_sigma`=0, `out_index`=0, `calc_accum`=0, `calc_bias`=0, `busy`=0, `done`=0, state IDLE.
- Reset asserted mid-pass aborts immediately. No partial output is produced and no `done` is issued.
- Throughput: one beat per cycle under continuous `in_valid`.
- Latency: when the last beat is accepted at edge t, `out_valid` rises after edge t+1, i.e. two cycles after the beat is presented.
- Minimum cycles per neuron: NUM_INPUTS + 2 (ACCUM beats + EVAL + OUTPUT with `out_ready` held high).
- `done` asserts in the cycle after the final handshake, coincident with state IDLE. A `start` in that same cycle launches a new pass.
- `in_valid` low in ACCUM stalls the pass with no state change.

## Configuration
- `SIGMOID_SEQ_SAT_EN` defined: the accumulator saturates at +8191 and -8192. Once clamped it stays clamped until further beats move it back inside the range.
- Not defined: the accumulator wraps modulo 2^14 (two's complement).

## Test plan
- NUM_INPUTS=4, NUM_NEURONS=2; neuron 0 all pixel=15, weight=1, bias=0 (accum 60); neuron 1 all pixel=15, weight=-8 (accum -480) -> `out_sigma`=8, index 0; then `out_sigma`=0, index 1; then `done` pulse.
- Beats pixel=1, weights {1,-1,0,0}, bias=0 -> `calc_accum`=0, `out_sigma`=4. Same beats with weights {-1,-1,0,0}, bias=1 -> `calc_accum`=-2, `out_sigma`=4.
- `out_ready` held low 5 cycles in OUTPUT -> `out_valid`, `out_sigma` and `out_index` stable, `in_ready`=0, input beats not consumed. `out_ready` high -> the next neuron starts.
- NUM_INPUTS=100, pixel=15, weight=-8 (sum -12000) -> with `SIGMOID_SEQ_SAT_EN` `calc_accum`=-8192 and `out_sigma`=0; without it `calc_accum`=4384 and `out_sigma`=8.
- `n_rst` asserted during the third beat of neuron 1 -> all outputs return to their reset values immediately and no `done` is produced. `start` after release begins again at index 0.
- `in_valid` toggled every other cycle -> same results as scenario 1, with the pass taking 4 extra cycles per neuron.
